// File: rtl/commit_redirect.sv
// Commit stage after the branch/PC-relative execute unit.
// Takes one exec result per handshake. It registers the GPR writeback and
// counts retired instructions. On a taken control transfer it pulses a fetch
// redirect and then holds flush for a programmable number of cycles.
// A taken target that is not 4-byte aligned raises a precise exception.
// The stage then halts until the exception is acknowledged.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | accepting results (in_ready=1)
// FLUSH | redirect issued, flush held while down-counter runs to zero
// HALT  | misaligned-target exception pending, waiting for exc_ack
module commit_redirect #(
   parameter int XLEN         = 32,
   parameter int REG_IDX_W    = 5,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_rd_we,
   input  logic [REG_IDX_W-1:0] in_rd_idx,
   input  logic [XLEN-1:0]      in_rd_val,
   input  logic                 in_br_valid,
   input  logic [XLEN-1:0]      in_br_target,
   output logic                 rf_we,
   output logic [REG_IDX_W-1:0] rf_waddr,
   output logic [XLEN-1:0]      rf_wdata,
   output logic                 redirect_valid,
   output logic [XLEN-1:0]      redirect_pc,
   output logic                 flush,
   output logic                 exc_valid,
   output logic [XLEN-1:0]      exc_tval,
   input  logic                 exc_ack,
   output logic [63:0]          instret
);

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_FLUSH = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

   // Counter holds the remaining flush cycles after the current one.
   localparam logic [3:0] C_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   logic [1:0]           r_state;
   logic [3:0]           r_cnt;
   logic                 r_rf_we;
   logic [REG_IDX_W-1:0] r_rf_waddr;
   logic [XLEN-1:0]      r_rf_wdata;
   logic                 r_redirect_valid;
   logic [XLEN-1:0]      r_redirect_pc;
   logic                 r_flush;
   logic                 r_exc_valid;
   logic [XLEN-1:0]      r_exc_tval;
   logic [63:0]          r_instret;

   logic w_accept;
   logic w_misaligned;
   logic w_wr_rd;

   assign in_ready     = (r_state == S_RUN);
   assign w_accept     = in_valid && in_ready;
   assign w_misaligned = in_br_valid && (in_br_target[1:0] != 2'b00);
   assign w_wr_rd      = in_rd_we && (in_rd_idx != '0);

   // Sequencer. Writeback and redirect are single-cycle pulses. Flush and
   // exception are held by their states.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state          <= S_RUN;
         r_cnt            <= '0;
         r_rf_we          <= 1'b0;
         r_rf_waddr       <= '0;
         r_rf_wdata       <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
         r_flush          <= 1'b0;
         r_exc_valid      <= 1'b0;
         r_exc_tval       <= '0;
         r_instret        <= '0;
      end else begin
         r_rf_we          <= 1'b0;
         r_redirect_valid <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (w_accept) begin
                  if (w_misaligned) begin
                     // Precise trap: nothing from this instruction retires.
                     r_exc_valid <= 1'b1;
                     r_exc_tval  <= in_br_target;
                     r_state     <= S_HALT;
                  end else begin
                     r_rf_we    <= w_wr_rd;
                     r_rf_waddr <= in_rd_idx;
                     r_rf_wdata <= in_rd_val;
                     r_instret  <= r_instret + 64'd1;
                     if (in_br_valid) begin
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= in_br_target;
                        r_flush          <= 1'b1;
                        r_cnt            <= C_FLUSH_LOAD;
                        r_state          <= S_FLUSH;
                     end
                  end
               end
            end
            S_FLUSH: begin
               if (r_cnt == 4'd0) begin
                  r_flush <= 1'b0;
                  r_state <= S_RUN;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_HALT: begin
               if (exc_ack) begin
                  r_exc_valid <= 1'b0;
                  r_state     <= S_RUN;
               end
            end
            default: begin
               r_flush     <= 1'b0;
               r_exc_valid <= 1'b0;
               r_state     <= S_RUN;
            end
         endcase
      end
   end

   assign rf_we          = r_rf_we;
   assign rf_waddr       = r_rf_waddr;
   assign rf_wdata       = r_rf_wdata;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign flush          = r_flush;
   assign exc_valid      = r_exc_valid;
   assign exc_tval       = r_exc_tval;
   assign instret        = r_instret;

endmodule

// File: tb/tb_commit_redirect.sv
// Bench for commit_redirect: scoreboard of hand-computed expected results,
// plus directed timing checks around flush, halt and reset.
module tb_commit_redirect;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_rd_we;
   logic [4:0]  in_rd_idx;
   logic [31:0] in_rd_val;
   logic        in_br_valid;
   logic [31:0] in_br_target;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        exc_valid;
   logic [31:0] exc_tval;
   logic        exc_ack;
   logic [63:0] instret;

   commit_redirect #(.XLEN(32), .REG_IDX_W(5), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rd_we(in_rd_we), .in_rd_idx(in_rd_idx), .in_rd_val(in_rd_val),
      .in_br_valid(in_br_valid), .in_br_target(in_br_target),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush(flush), .exc_valid(exc_valid), .exc_tval(exc_tval),
      .exc_ack(exc_ack), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        redir;
      logic [31:0] rpc;
      logic        flush;
      logic        exc;
      logic [31:0] tval;
      logic [63:0] instret;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor: a retirement (instret moves) or a new exception is one DUT result.
   initial begin : monitor
      logic [63:0] prev_inst;
      logic        prev_exc;
      exp_t        e;
      logic        ok;
      prev_inst = '0;
      prev_exc  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_inst = '0;
            prev_exc  = 1'b0;
         end else begin
            if ((instret !== prev_inst) || (exc_valid && !prev_exc)) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_result instret=%0d exc_valid=%0b required no result",
                           instret, exc_valid);
               end else begin
                  e  = exp_q.pop_front();
                  ok = (rf_we === e.we) && (redirect_valid === e.redir) && (flush === e.flush) &&
                       (exc_valid === e.exc) && (instret === e.instret);
                  if (e.we)    ok = ok && (rf_waddr === e.waddr) && (rf_wdata === e.wdata);
                  if (e.redir) ok = ok && (redirect_pc === e.rpc);
                  if (e.exc)   ok = ok && (exc_tval === e.tval);
                  if (!ok) begin
                     errors++;
                     $display("FAIL result actual we=%0b wa=%0d wd=%0h rv=%0b rpc=%0h fl=%0b ex=%0b tv=%0h ir=%0d required we=%0b wa=%0d wd=%0h rv=%0b rpc=%0h fl=%0b ex=%0b tv=%0h ir=%0d",
                              rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc, flush,
                              exc_valid, exc_tval, instret, e.we, e.waddr, e.wdata, e.redir,
                              e.rpc, e.flush, e.exc, e.tval, e.instret);
                  end
               end
            end
            prev_inst = instret;
            prev_exc  = exc_valid;
         end
      end
   end

   // Issue one exec result and queue its hand-computed expected response.
   task automatic issue(input logic we, input logic [4:0] idx, input logic [31:0] val,
                        input logic br, input logic [31:0] tgt,
                        input logic e_we, input logic e_redir, input logic e_flush,
                        input logic e_exc, input logic [63:0] e_inst);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout in_ready=%0b required 1", in_ready);
         return;
      end
      in_rd_we     = we;
      in_rd_idx    = idx;
      in_rd_val    = val;
      in_br_valid  = br;
      in_br_target = tgt;
      in_valid     = 1'b1;
      e.we = e_we;  e.waddr = idx;  e.wdata = val;
      e.redir = e_redir;  e.rpc = tgt;  e.flush = e_flush;
      e.exc = e_exc;  e.tval = tgt;  e.instret = e_inst;
      exp_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_outputs", {rf_we, redirect_valid, flush, exc_valid, 32'(rf_waddr), 28'd0},
          64'd0);
      chk("rst_instret", instret, 64'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin : stim
      int n;
      rst = 1'b0;
      in_valid = 1'b0;  in_rd_we = 1'b0;  in_rd_idx = '0;  in_rd_val = '0;
      in_br_valid = 1'b0;  in_br_target = '0;  exc_ack = 1'b0;
      #12;
      chk("por_in_ready", 64'(in_ready), 64'd1);
      chk("por_regs", {rf_we, redirect_valid, flush, exc_valid, rf_wdata, 28'd0}, 64'd0);
      chk("por_tval_pc", {exc_tval, redirect_pc}, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // ADDI x5 = 0x1234
      issue(1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd1);
      @(negedge clk);
      chk("addi_in_ready", 64'(in_ready), 64'd1);
      // write to x0, then not-taken branch
      issue(1'b1, 5'd0, 32'h55, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd2);
      issue(1'b0, 5'd7, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3);

      // taken JAL x1 = 0x104 -> 0x200
      issue(1'b1, 5'd1, 32'h104, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 64'd4);
      @(negedge clk);
      chk("jal_n1_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("jal_n2_redirect", 64'(redirect_valid), 64'd0);
      chk("jal_n2_flush", 64'(flush), 64'd1);
      chk("jal_n2_in_ready", 64'(in_ready), 64'd0);
      chk("jal_n2_rf_we", 64'(rf_we), 64'd0);
      @(negedge clk);
      chk("jal_n3_flush", 64'(flush), 64'd0);
      chk("jal_n3_in_ready", 64'(in_ready), 64'd1);

      // misaligned taken branch to 0x202
      issue(1'b0, 5'd0, 32'h0, 1'b1, 32'h202, 1'b0, 1'b0, 1'b0, 1'b1, 64'd4);
      @(negedge clk);
      chk("exc_n1_in_ready", 64'(in_ready), 64'd0);
      // upstream presents a result while halted; it must be ignored
      in_rd_we = 1'b1;  in_rd_idx = 5'd9;  in_rd_val = 32'hdead;  in_br_valid = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("halt_exc_valid", 64'(exc_valid), 64'd1);
         chk("halt_in_ready", 64'(in_ready), 64'd0);
         chk("halt_instret", instret, 64'd4);
         chk("halt_rf_we", 64'(rf_we), 64'd0);
      end
      in_valid = 1'b0;
      exc_ack  = 1'b1;
      @(negedge clk);
      exc_ack = 1'b0;
      chk("ack_exc_valid", 64'(exc_valid), 64'd0);
      chk("ack_in_ready", 64'(in_ready), 64'd1);
      chk("ack_instret", instret, 64'd4);
      // exc_ack outside HALT has no effect
      exc_ack = 1'b1;
      @(negedge clk);
      exc_ack = 1'b0;
      chk("stray_ack_exc", 64'(exc_valid), 64'd0);
      chk("stray_ack_ready", 64'(in_ready), 64'd1);

      // 10 back-to-back results after a fresh reset
      do_reset();
      for (int i = 1; i <= 10; i++)
         issue(1'b1, 5'(i), 32'(i * 32'h11), 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'(i));
      @(negedge clk);
      chk("b2b_instret", instret, 64'd10);
      @(negedge clk);
      chk("b2b_rf_we_pulse", 64'(rf_we), 64'd0);

      // reset in cycle N+2 of a flush
      issue(1'b1, 5'd2, 32'h8, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1'b0, 64'd11);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_flush", 64'(flush), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("rst_flush_flush", 64'(flush), 64'd0);
      chk("rst_flush_ready", 64'(in_ready), 64'd1);
      chk("rst_flush_instret", instret, 64'd0);
      chk("rst_flush_redirect", 64'(redirect_valid), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_flush", 64'(flush), 64'd0);

      // reset while halted on a misaligned target
      issue(1'b1, 5'd4, 32'h77, 1'b1, 32'h401, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
      @(negedge clk);
      chk("pre_rst_exc", 64'(exc_valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("rst_halt_exc", 64'(exc_valid), 64'd0);
      chk("rst_halt_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      issue(1'b1, 5'd3, 32'habc, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd1);

      n = 0;
      while (exp_q.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/commit_redirect.md
Name: commit_redirect

Overview:
- Commit stage directly downstream of the PC-relative/branch execute unit.
- Accepts one exec result per handshake and registers the GPR writeback.
- On a taken branch or jump: issues a one-cycle fetch redirect and holds a pipeline flush for a fixed number of cycles.
- Raises a precise instruction-address-misaligned exception for taken targets not 4-byte aligned (no C extension), then halts until acknowledged.
- Maintains a 64-bit retired-instruction counter.

Parameters:
XLEN, 32, GPR/address width
REG_IDX_W, 5, register index width
FLUSH_CYCLES, 2, cycles flush is held after a redirect; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  exec result valid
in_ready  out  1  stage can accept
in_rd_we  in  1  instruction writes rd (0 for BRANCH)
in_rd_idx  in  REG_IDX_W  destination register
in_rd_val  in  XLEN  writeback value
in_br_valid  in  1  control transfer taken
in_br_target  in  XLEN  taken target
rf_we  out  1  register-file write enable
rf_waddr  out  REG_IDX_W  write index
rf_wdata  out  XLEN  write data
redirect_valid  out  1  fetch redirect pulse
redirect_pc  out  XLEN  redirect target
flush  out  1  kill younger in-flight instructions
exc_valid  out  1  misaligned-target exception pending
exc_tval  out  XLEN  faulting target
exc_ack  in  1  exception handled; resume
instret  out  64  retired instruction count

Behaviour:
- Reset: rst low asynchronously clears all registered outputs to 0 (rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc, flush, exc_valid, exc_tval, instret) and sets state to RUN. in_ready=1 while rst is low and after release.
- States:
  - RUN: in_ready=1.
  - FLUSH: in_ready=0; down-counter active.
  - HALT: in_ready=0; exc_valid=1.
- Accept: in_valid && in_ready at a rising edge (edge N). Results appear registered in cycle N+1 (latency 1).
- Misaligned case (in_br_valid=1 and in_br_target[1:0]!=0), in cycle N+1:
  - exc_valid=1, exc_tval=in_br_target.
  - rf_we=0, redirect_valid=0, flush=0; instret unchanged.
  - State goes to HALT.
- Normal case, in cycle N+1:
  - rf_we = in_rd_we && (in_rd_idx != 0); rf_waddr and rf_wdata are captured.
  - instret increments by 1, wrapping modulo 2^64.
  - rf_we is a single-cycle pulse per accept.
- Taken case (normal case with in_br_valid=1):
  - redirect_valid=1 for exactly cycle N+1; redirect_pc=in_br_target.
  - flush=1 for cycles N+1..N+FLUSH_CYCLES.
  - State is FLUSH; counter loads FLUSH_CYCLES-1 and decrements each cycle; at 0 the next state is RUN.
  - in_ready=1 again in cycle N+FLUSH_CYCLES+1.
  - A taken JAL writes rd and redirects in the same cycle.
- HALT:
  - exc_valid is held until exc_ack is sampled high; the next cycle is RUN with exc_valid=0.
  - exc_ack outside HALT is ignored.
- Invariants:
  - redirect_valid and exc_valid are never high together.
  - No input is accepted while flush=1 or exc_valid=1.
  - in_valid while in_ready=0 has no effect; upstream holds its data.
- Back-to-back non-branch accepts in RUN retire one per cycle.
- rst asserted mid-FLUSH or mid-HALT aborts immediately to the reset state; no pending redirect or exception survives.
- redirect_pc and exc_tval hold their last value when their valid signal is low. Verification checks them only while the corresponding valid is high.

Test Plan:
- Reset then ADDI-like result (rd_we=1, rd=5, val=0x1234, br_valid=0) -> next cycle rf_we=1, waddr=5, wdata=0x1234; instret=1; in_ready stays 1.
- Write to x0 (rd_we=1, rd=0) -> rf_we=0 and instret increments; BRANCH not taken (rd_we=0) -> rf_we=0 and instret increments.
- Taken JAL (rd=1, val=0x104, target=0x200), FLUSH_CYCLES=2 -> cycle N+1: rf_we=1, redirect_valid=1, redirect_pc=0x200, flush=1. Cycle N+2: redirect_valid=0, flush=1, in_ready=0. Cycle N+3: flush=0, in_ready=1.
- Taken branch to 0x202 -> exc_valid=1, exc_tval=0x202, rf_we=0, instret unchanged, in_ready=0. Hold exc_ack=0 for 5 cycles -> state unchanged. exc_ack=1 -> next cycle exc_valid=0, in_ready=1.
- 10 back-to-back non-branch results -> 10 consecutive rf_we pulses; instret=10.
- Drive rst low in cycle N+2 of a FLUSH -> flush=0 and in_ready=1 immediately; instret=0.
